// File: rtl/crp16_memory_system.sv
`default_nettype none
// ============================================================================
//  Module      : crp16_memory_system
//  Description : Responder side of the CRP16 dual-port memory interface.
//                Port A is a read-only instruction fetch port and port B a
//                load/store data port. The block contains the RAM array, a
//                small MMIO block (LEDs, switches, cycle counter, loader word
//                count) and a byte-stream program loader that holds the CPU
//                in reset while it fills RAM.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock, reset          system clock, synchronous active-high reset
//    address_a/q_a         fetch address / combinational fetch data
//    data_a, wren_a        present for interface symmetry, not used
//    address_b/data_b      data address / store data
//    wren_b, q_b           store enable / combinational load data
//    switches, leds        board switches in, LED register out
//    load_en, load_valid   loader mode request, byte strobe
//    load_byte             program byte, low byte of each word first
//    load_ready            loader accepts a byte this cycle
//    load_count            words written since the last loader entry
//    cpu_reset             reset for the datapath
// ============================================================================
module crp16_memory_system #(
    parameter int DEPTH = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address_a,
    input  logic [15:0] data_a,
    input  logic        wren_a,
    output logic [15:0] q_a,
    input  logic [15:0] address_b,
    input  logic [15:0] data_b,
    input  logic        wren_b,
    output logic [15:0] q_b,
    input  logic [15:0] switches,
    output logic [15:0] leds,
    input  logic        load_en,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    output logic        load_ready,
    output logic [15:0] load_count,
    output logic        cpu_reset
);

    localparam int          c_aw         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] c_depth      = 17'(DEPTH);
    localparam logic [15:0] c_addr_leds  = 16'hFFF0;
    localparam logic [15:0] c_addr_sw    = 16'hFFF1;
    localparam logic [15:0] c_addr_cnt   = 16'hFFF2;
    localparam logic [15:0] c_addr_lc    = 16'hFFF3;
    localparam logic [15:0] c_unmapped   = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LOAD_LO = 2'd1,
        ST_LOAD_HI = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_mem [0:DEPTH-1];
    logic [15:0] r_leds;
    logic [15:0] r_cnt;
    logic [15:0] r_load_count;
    logic [7:0]  r_low;

    logic        w_run;
    logic        w_store;
    logic        w_ld_lo;
    logic        w_ld_word;

    // Port A is read-only; its write-side pins are deliberately unused.
    logic        w_unused_port_a;
    assign w_unused_port_a = ^{data_a, wren_a};

    assign w_run     = (r_state == ST_RUN);
    // Stores only land while the CPU owns the memory; anything issued while
    // the loader is active (or under reset) is dropped.
    assign w_store   = !reset && w_run && wren_b;
    assign w_ld_lo   = !reset && (r_state == ST_LOAD_LO) && load_en && load_valid;
    assign w_ld_word = !reset && (r_state == ST_LOAD_HI) && load_en && load_valid;

    // ------------------------------------------------------------------
    // Address map decode shared by both read ports
    // ------------------------------------------------------------------
    function automatic logic [15:0] read_map(input logic [15:0] addr);
        logic [15:0] v;
        if ({1'b0, addr} < c_depth) begin
            v = r_mem[addr[c_aw-1:0]];
        end else if (addr < c_addr_leds) begin
            v = c_unmapped;
        end else begin
            case (addr)
                c_addr_leds: v = r_leds;
                c_addr_sw:   v = switches;
                c_addr_cnt:  v = r_cnt;
                c_addr_lc:   v = r_load_count;
                default:     v = 16'h0000;
            endcase
        end
        return v;
    endfunction

    always_comb begin
        q_a = read_map(address_a);
        q_b = read_map(address_b);
    end

    // ------------------------------------------------------------------
    // RAM array: never reset. CPU stores and loader writes are mutually
    // exclusive because they depend on disjoint FSM states.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_store && ({1'b0, address_b} < c_depth)) begin
            r_mem[address_b[c_aw-1:0]] <= data_b;
        end else if (w_ld_word && ({1'b0, r_load_count} < c_depth)) begin
            r_mem[r_load_count[c_aw-1:0]] <= {load_byte, r_low};
        end
    end

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (load_en) w_state_next = ST_LOAD_LO;
            end
            ST_LOAD_LO: begin
                if (!load_en)        w_state_next = ST_RUN;
                else if (load_valid) w_state_next = ST_LOAD_HI;
            end
            ST_LOAD_HI: begin
                if (!load_en)        w_state_next = ST_RUN;
                else if (load_valid) w_state_next = ST_LOAD_LO;
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_load_count <= 16'h0000;
            r_low        <= 8'h00;
        end else begin
            if (w_run && load_en) begin
                r_load_count <= 16'h0000;
            end else if (w_ld_word) begin
                // Keeps counting past the end of RAM so the host can see how
                // many words it sent even when some were dropped.
                r_load_count <= r_load_count + 16'd1;
            end
            if (w_ld_lo) begin
                r_low <= load_byte;
            end
        end
    end

    // ------------------------------------------------------------------
    // MMIO registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_leds <= 16'h0000;
        end else if (w_store && (address_b == c_addr_leds)) begin
            r_leds <= data_b;
        end
    end

    // The cycle counter only advances while the CPU runs; a store to it
    // clears it and wins over the increment in that cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= 16'h0000;
        end else if (w_run) begin
            if (wren_b && (address_b == c_addr_cnt)) begin
                r_cnt <= 16'h0000;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign leds       = r_leds;
    assign load_count = r_load_count;
    assign load_ready = load_en & !w_run;
    assign cpu_reset  = reset | !w_run;

endmodule
`default_nettype wire

// File: tb/tb_crp16_memory_system.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crp16_memory_system
//  Description : Scoreboard bench for crp16_memory_system. Stimulus pushes
//                expected outputs from a behavioural model; a negedge monitor
//                pops and compares them. A second instance with DEPTH=4
//                exercises out-of-range loader writes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_crp16_memory_system;

    localparam int DEPTH = 4096;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] address_a, data_a, address_b, data_b, switches;
    logic        wren_a, wren_b, load_en, load_valid;
    logic [7:0]  load_byte;
    logic [15:0] q_a, q_b, leds, load_count;
    logic        load_ready, cpu_reset;
    logic [15:0] q_a4, q_b4, leds4, load_count4;
    logic        load_ready4, cpu_reset4;

    always #5 clock = ~clock;

    crp16_memory_system #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .q_a(q_a),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .q_b(q_b),
        .switches(switches), .leds(leds),
        .load_en(load_en), .load_valid(load_valid), .load_byte(load_byte),
        .load_ready(load_ready), .load_count(load_count), .cpu_reset(cpu_reset)
    );

    crp16_memory_system #(.DEPTH(4)) dut4 (
        .clock(clock), .reset(reset),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .q_a(q_a4),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .q_b(q_b4),
        .switches(switches), .leds(leds4),
        .load_en(load_en), .load_valid(load_valid), .load_byte(load_byte),
        .load_ready(load_ready4), .load_count(load_count4), .cpu_reset(cpu_reset4)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int          cyc;
        int          sig;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [15:0] dut_out(input int sig);
        case (sig)
            0:  return q_a;
            1:  return q_b;
            2:  return leds;
            3:  return load_count;
            4:  return {15'd0, cpu_reset};
            5:  return {15'd0, load_ready};
            6:  return q_a4;
            7:  return q_b4;
            8:  return leds4;
            9:  return load_count4;
            10: return {15'd0, cpu_reset4};
            11: return {15'd0, load_ready4};
            default: return 16'hxxxx;
        endcase
    endfunction

    function automatic void expect_val(input string nm, input int sig, input logic [15:0] v);
        sb.push_back('{cyc, sig, v, nm});
    endfunction

    always @(negedge clock) begin : monitor
        exp_t        e;
        logic [15:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = dut_out(e.sig);
            n_cmp++;
            if (e.cyc != cyc || act !== e.exp) begin
                n_bad++;
                $display("FAIL %s (cycle %0d): got %h expected %h", e.name, cyc, act, e.exp);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    logic [15:0] m_leds = '0, m_cnt = '0, m_lc = '0;
    bit          m_load = 1'b0;
    logic [7:0]  m_bytes[$];
    logic [7:0]  ld_q[$];

    function automatic logic [15:0] mread(input logic [15:0] a);
        if (int'(a) < DEPTH)  return m_mem[a[11:0]];
        if (a < 16'hFFF0)     return 16'hDEAD;
        case (a)
            16'hFFF0: return m_leds;
            16'hFFF1: return switches;
            16'hFFF2: return m_cnt;
            16'hFFF3: return m_lc;
            default:  return 16'h0000;
        endcase
    endfunction

    function automatic bit pred(input logic [15:0] a);
        return (int'(a) >= DEPTH) || m_known[a[11:0]];
    endfunction

    function automatic void exp_reads(input string nm);
        if (pred(address_a)) expect_val({nm, "_qa"}, 0, mread(address_a));
        if (pred(address_b)) expect_val({nm, "_qb"}, 1, mread(address_b));
    endfunction

    function automatic void exp_ctrl(input string nm);
        expect_val({nm, "_cpu_reset"},  4, {15'd0, reset | m_load});
        expect_val({nm, "_load_ready"}, 5, {15'd0, load_en & m_load});
        expect_val({nm, "_load_count"}, 3, m_lc);
        expect_val({nm, "_leds"},       2, m_leds);
    endfunction

    // One clock edge; the model applies the rules to the inputs held there.
    task automatic tick();
        @(posedge clock);
        if (reset) begin
            m_load = 1'b0; m_lc = '0; m_cnt = '0; m_leds = '0;
            m_bytes.delete();
        end else if (!m_load) begin
            if (wren_b) begin
                if (int'(address_b) < DEPTH) begin
                    m_mem[address_b[11:0]]   = data_b;
                    m_known[address_b[11:0]] = 1'b1;
                end else if (address_b == 16'hFFF0) begin
                    m_leds = data_b;
                end
            end
            m_cnt = (wren_b && address_b == 16'hFFF2) ? 16'h0000 : m_cnt + 16'd1;
            if (load_en) begin
                m_load = 1'b1; m_lc = '0; m_bytes.delete();
            end
        end else if (!load_en) begin
            m_load = 1'b0;
            m_bytes.delete();
        end else if (load_valid) begin
            m_bytes.push_back(load_byte);
            if (m_bytes.size() == 2) begin
                if (int'(m_lc) < DEPTH) begin
                    m_mem[m_lc[11:0]]   = {m_bytes[1], m_bytes[0]};
                    m_known[m_lc[11:0]] = 1'b1;
                end
                m_lc = m_lc + 16'd1;
                m_bytes.delete();
            end
        end
        #1;
        cyc++;
    endtask

    task automatic idle();
        reset = 1'b0; wren_b = 1'b0; load_en = 1'b0; load_valid = 1'b0;
    endtask

    task automatic set_bytes(input logic [63:0] v, input int n);
        ld_q.delete();
        for (int i = 0; i < n; i++) ld_q.push_back(v[8*i +: 8]);
    endtask

    // Enter loader, stream ld_q, then drop load_en with a stray valid byte.
    task automatic load_seq(input bit gaps, input bit store_in_lo);
        idle();
        load_en = 1'b1; address_b = 16'hFFF2; address_a = 16'hFFF3;
        exp_ctrl("ld_entry"); exp_reads("ld_entry"); tick();
        for (int i = 0; i < ld_q.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                load_valid = 1'b0; wren_b = 1'b0; address_b = 16'hFFF2;
                exp_ctrl("ld_gap"); exp_reads("ld_gap"); tick();
            end
            load_valid = 1'b1; load_byte = ld_q[i];
            if (store_in_lo && i == 0) begin
                wren_b = 1'b1; address_b = 16'd2; data_b = 16'hFFFF;
            end else begin
                wren_b = 1'b0; address_b = 16'hFFF2;
            end
            address_a = m_lc;
            exp_ctrl("ld_byte"); exp_reads("ld_byte"); tick();
        end
        wren_b = 1'b0; load_valid = 1'b1; load_byte = 8'hEE; load_en = 1'b0;
        address_b = 16'hFFF2;
        exp_ctrl("ld_exit"); exp_reads("ld_exit"); tick();
        load_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wren_a = 1'b0; data_a = '0; wren_b = 1'b0; data_b = '0;
        address_a = 16'hFFF2; address_b = 16'hFFF3; switches = '0;
        load_en = 1'b0; load_valid = 1'b0; load_byte = '0;
        tick();
        for (int i = 0; i < 2; i++) begin
            exp_ctrl("rst"); exp_reads("rst");
            expect_val("rst_cpu_reset", 4, 16'd1);
            tick();
        end

        // Counter counts run cycles from reset, then clears on a store.
        idle(); address_b = 16'hFFF2;
        for (int i = 0; i < 10; i++) tick();
        expect_val("cnt_after10", 1, 16'd10); exp_reads("cnt10");
        wren_b = 1'b1; data_b = 16'h5555; tick();
        wren_b = 1'b0; expect_val("cnt_clear", 1, 16'd0); tick();
        exp_reads("cnt_run"); tick();

        // Six-byte load.
        set_bytes(64'hABCD_5678_1234, 6); load_seq(1'b0, 1'b0);
        address_a = 16'd0; address_b = 16'hFFF3;
        expect_val("t1_qa0", 0, 16'h1234); expect_val("t1_lc_rd", 1, 16'd3);
        expect_val("t1_lc", 3, 16'd3); expect_val("t1_cpu_reset", 4, 16'd0);
        tick();
        address_a = 16'd1; address_b = 16'd2;
        expect_val("t1_ram1", 0, 16'h5678); expect_val("t1_ram2", 1, 16'hABCD);
        tick();

        // Odd byte count, store attempted during LOAD_LO.
        set_bytes(64'h33_2211, 3); load_seq(1'b0, 1'b1);
        address_a = 16'd0; address_b = 16'd1;
        expect_val("odd_ram0", 0, 16'h2211); expect_val("odd_ram1", 1, 16'h5678);
        expect_val("odd_lc", 3, 16'd1); tick();
        address_a = 16'd2; expect_val("lo_store_dropped", 0, 16'hABCD); tick();

        // Reset in the middle of a load.
        load_en = 1'b1; tick();
        load_valid = 1'b1; load_byte = 8'h77; tick();
        load_byte = 8'h66; tick();
        load_byte = 8'h99; tick();
        reset = 1'b1; load_byte = 8'h88; exp_ctrl("midrst"); tick();
        idle(); address_a = 16'd0; address_b = 16'd1;
        expect_val("midrst_cpu_reset", 4, 16'd0); expect_val("midrst_lc", 3, 16'd0);
        expect_val("midrst_ram0", 0, 16'h6677); expect_val("midrst_ram1", 1, 16'h5678);
        tick();

        // Store/read collision.
        wren_b = 1'b1; address_b = 16'd5; data_b = 16'h1111; tick();
        address_a = 16'd5; data_b = 16'hBEEF;
        expect_val("st_old_a", 0, 16'h1111); expect_val("st_old_b", 1, 16'h1111); tick();
        wren_b = 1'b0;
        expect_val("st_new_a", 0, 16'hBEEF); expect_val("st_new_b", 1, 16'hBEEF); tick();

        // MMIO.
        wren_b = 1'b1; address_b = 16'hFFF0; data_b = 16'h00A5; tick();
        wren_b = 1'b0; address_a = 16'hFFF0;
        expect_val("leds", 2, 16'h00A5); expect_val("leds_rd", 0, 16'h00A5); tick();
        switches = 16'h1234; address_a = 16'hFFF1; address_b = 16'hFFF5;
        expect_val("switches", 0, 16'h1234); expect_val("fff5", 1, 16'h0000); tick();
        address_a = 16'(DEPTH); address_b = 16'(DEPTH); wren_b = 1'b1; data_b = 16'h7777;
        expect_val("unmapped", 0, 16'hDEAD); tick();
        wren_b = 1'b0; expect_val("unmapped_wr", 1, 16'hDEAD); tick();

        // Randomised traffic.
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 15) == 0) begin
                ld_q.delete();
                for (int k = $urandom_range(2, 9); k > 0; k--) ld_q.push_back(8'($urandom));
                load_seq(1'b1, 1'b0);
            end else begin
                logic [15:0] ad [2];
                for (int p = 0; p < 2; p++) begin
                    case ($urandom_range(0, 5))
                        0, 1, 2: ad[p] = 16'($urandom_range(0, 63));
                        3:       ad[p] = 16'($urandom_range(16'hFFF0, 16'hFFFF));
                        4:       ad[p] = 16'($urandom_range(DEPTH, 16'hFFEF));
                        default: ad[p] = 16'($urandom_range(0, DEPTH - 1));
                    endcase
                end
                idle(); switches = 16'($urandom);
                address_a = ad[0]; address_b = ad[1];
                wren_b = 1'($urandom_range(0, 1)); data_b = 16'($urandom);
                exp_ctrl("rnd"); exp_reads("rnd"); tick();
            end
        end

        // Out-of-range loader writes on the DEPTH=4 instance.
        ld_q.delete();
        for (int w = 0; w < 5; w++) begin
            logic [15:0] wv;
            wv = 16'hA001 + 16'(w);
            ld_q.push_back(wv[7:0]); ld_q.push_back(wv[15:8]);
        end
        load_seq(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            address_a = 16'(i);
            expect_val("d4_ram", 6, 16'hA001 + 16'(i)); tick();
        end
        address_a = 16'd4;
        expect_val("d4_unmapped", 6, 16'hDEAD); expect_val("d4_lc", 9, 16'd5);
        expect_val("d4_lc_big", 3, 16'd5); tick();

        // Counter wrap.
        idle(); wren_b = 1'b1; address_b = 16'hFFF2; tick();
        wren_b = 1'b0;
        for (int i = 0; i < 65535; i++) tick();
        expect_val("cnt_ffff", 1, 16'hFFFF); tick();
        expect_val("cnt_wrap", 1, 16'h0000); tick();

        tick(); tick();
        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
